divide_8by4_seq: RTL

Sequential restoring divider: an unsigned DIVIDEND_W-bit dividend divided by an unsigned DIVISOR_W-bit divisor, producing a DIVIDEND_W-bit quotient and a DIVISOR_W-bit remainder. It produces one quotient bit per clock under a start/busy/done handshake. It is the inverse datapath to the team's combinational 4x4 multiplier: the multiplier's 8-bit product feeds this block, which recovers either factor. Results for dividend = A*B, divisor = B (B ≠ 0) must return quotient = A and remainder = 0.

---
 rtl/divide_8by4_seq_if.sv | 26 ++
 rtl/divide_8by4_seq.sv | 126 ++++++++++++
 2 files changed

// File: rtl/divide_8by4_seq_if.sv
// Request/response bundle for the sequential 8/4 restoring divider.
// The master issues start with operands; the slave (divider) returns
// busy/done and the held results.
interface divide_8by4_seq_if #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
);
   logic                  start;
   logic [DIVIDEND_W-1:0] dividend;
   logic [DIVISOR_W-1:0]  divisor;
   logic                  busy;
   logic                  done;
   logic [DIVIDEND_W-1:0] quotient;
   logic [DIVISOR_W-1:0]  remainder;
   logic                  div_by_zero;

   modport master (
      output start, dividend, divisor,
      input  busy, done, quotient, remainder, div_by_zero
   );

   modport slave (
      input  start, dividend, divisor,
      output busy, done, quotient, remainder, div_by_zero
   );
endinterface

// File: rtl/divide_8by4_seq.sv
// Sequential restoring divider: unsigned DIVIDEND_W / DIVISOR_W, one
// quotient bit per clock, start/busy/done handshake.
// Optional feature macro: DIV_ZERO_CHECK_EN -- when defined, a zero divisor
// skips the RUN phase and reports div_by_zero with a one-cycle latency.
module divide_8by4_seq #(
   parameter int DIVIDEND_W = 8,
   parameter int DIVISOR_W  = 4
) (
   input logic             clk,
   input logic             rst,
   divide_8by4_seq_if.slave bus
);

   localparam int CNT_W = (DIVIDEND_W > 1) ? $clog2(DIVIDEND_W) : 1;
   localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state_q, state_d;

   // work_q starts as the dividend and fills with quotient bits from the LSB
   // as dividend bits leave from the MSB, so after DIVIDEND_W steps it holds
   // the quotient.
   logic [DIVIDEND_W-1:0] work_q;
   logic [DIVISOR_W-1:0]  dvsr_q;
   // The stored partial remainder is always below the divisor (or its top
   // bit is shifted out on the next step), so only the shifted/compare value
   // needs the extra bit.
   logic [DIVISOR_W-1:0]  rem_q;
   logic [CNT_W-1:0]      cnt_q;

   logic [DIVIDEND_W-1:0] quot_q;
   logic [DIVISOR_W-1:0]  remd_q;

   logic                  accept;
   logic                  zero_fast;
   logic                  last;
   logic [DIVISOR_W:0]    shifted;
   logic                  q_bit;
   logic [DIVISOR_W:0]    rem_step;
   logic [DIVIDEND_W-1:0] work_step;

   // Single restoring step plus handshake decode.
   always_comb begin
      accept    = (state_q != RUN) && bus.start;
`ifdef DIV_ZERO_CHECK_EN
      zero_fast = accept && (bus.divisor == '0);
`else
      zero_fast = 1'b0;
`endif
      last      = (cnt_q == LAST_STEP);
      shifted   = {rem_q, work_q[DIVIDEND_W-1]};
      q_bit     = (shifted >= {1'b0, dvsr_q});
      rem_step  = q_bit ? (shifted - {1'b0, dvsr_q}) : shifted;
      work_step = {work_q[DIVIDEND_W-2:0], q_bit};
   end

   // State register.
   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next-state: DONE behaves like IDLE for a new start, giving back-to-back.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE, DONE: begin
            if (accept) state_d = zero_fast ? DONE : RUN;
            else        state_d = IDLE;
         end
         RUN:        if (last) state_d = DONE;
         default:    state_d = IDLE;
      endcase
   end

   // Datapath: operand capture, per-cycle step, result update on done edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q <= '0;
         dvsr_q <= '0;
         rem_q  <= '0;
         cnt_q  <= '0;
         quot_q <= '0;
         remd_q <= '0;
      end else if (accept) begin
         work_q <= bus.dividend;
         dvsr_q <= bus.divisor;
         rem_q  <= '0;
         cnt_q  <= '0;
         if (zero_fast) begin
            quot_q <= '1;
            remd_q <= '0;
         end
      end else if (state_q == RUN) begin
         work_q <= work_step;
         rem_q  <= rem_step[DIVISOR_W-1:0];
         cnt_q  <= cnt_q + CNT_W'(1);
         if (last) begin
            quot_q <= work_step;
            remd_q <= rem_step[DIVISOR_W-1:0];
         end
      end
   end

`ifdef DIV_ZERO_CHECK_EN
   logic dbz_q;

   // Divide-by-zero flag follows the result it describes.
   always_ff @(posedge clk) begin
      if (rst)                          dbz_q <= 1'b0;
      else if (zero_fast)               dbz_q <= 1'b1;
      else if (state_q == RUN && last)  dbz_q <= 1'b0;
   end

   assign bus.div_by_zero = dbz_q;
`else
   assign bus.div_by_zero = 1'b0;
`endif

   assign bus.busy      = (state_q == RUN);
   assign bus.done      = (state_q == DONE);
   assign bus.quotient  = quot_q;
   assign bus.remainder = remd_q;

endmodule
